// File: rtl/drp_pkg.sv
// rtl/drp_pkg.sv - shared types and defaults for the DRP arbiter
package drp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam int          DEFAULT_TIMEOUT = 64;
  localparam int          DEFAULT_AW      = 9;
  localparam logic [15:0] RDATA_TIMEOUT   = 16'h0000;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin requester pick
module rr_select #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    any
);

  localparam int SW = $clog2(NREQ);

  int idx;

  // Scan offsets from highest to lowest so the pending requester nearest rr_ptr wins
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req[idx]) begin
        sel = SW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drp_arbiter.sv
// rtl/drp_arbiter.sv - round-robin arbiter sharing one DRP port among requesters
module drp_arbiter
  import drp_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int AW      = DEFAULT_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*16-1:0] req_di,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [15:0]        rdata,
  output logic               drp_en,
  output logic               drp_we,
  output logic [AW-1:0]      drp_addr,
  output logic [15:0]        drp_di,
  input  logic [15:0]        drp_do,
  input  logic               drp_rdy
);

  localparam int         SW       = $clog2(NREQ);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_q;
  logic          any;
  logic [7:0]    cnt;
  logic          timed_out;

  rr_select #(.NREQ(NREQ)) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr),
    .sel    (sel),
    .any    (any)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the single-cycle strobes (drp_en, done, err)
  always_comb begin
    state_nxt = state;
    drp_en    = 1'b0;
    done      = '0;
    err       = '0;
    case (state)
      IDLE: begin
        if (any) state_nxt = ISSUE;
      end
      ISSUE: begin
        drp_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // drp_rdy on the final counted cycle still completes normally
        if (drp_rdy || (cnt == CNT_LAST)) state_nxt = RESP;
      end
      RESP: begin
        if (timed_out) err = gnt;
        else           done = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, operand latches, timeout counter, read data and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      sel_q     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      drp_we    <= 1'b0;
      drp_addr  <= '0;
      drp_di    <= '0;
      rdata     <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            sel_q    <= sel;
            gnt      <= NREQ'(1) << sel;
            drp_we   <= req_we[sel];
            drp_addr <= req_addr[int'(sel)*AW +: AW];
            drp_di   <= req_di[int'(sel)*16 +: 16];
          end
        end
        ISSUE: begin
          cnt <= '0;
        end
        WAIT: begin
          if (drp_rdy) begin
            rdata     <= drp_do;
            timed_out <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            rdata     <= RDATA_TIMEOUT;
            timed_out <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          gnt    <= '0;
          rr_ptr <= (sel_q == SW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/drp_arbiter.md
DRP_ARBITER -- requirements
Module: drp_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles spent waiting for drp_rdy, 2..255.
REQ-003 Parameter AW, default 9: DRP address width.
REQ-004 Clock and reset:
- clk  in  1: DRP clock; the block uses one clock.
- rst  in  1: reset, asynchronous, active-high.
REQ-005 Requester ports, bundle index i in bits [i*W +: W]:
- req  in  NREQ: request pending, level.
- req_we  in  NREQ: 1 = write, 0 = read.
- req_addr  in  NREQ*AW: DRP address.
- req_di  in  NREQ*16: write data.
- gnt  out  NREQ: one-hot; high from arbitration until completion.
- done  out  NREQ: one-cycle completion pulse.
- err  out  NREQ: one-cycle timeout pulse.
- rdata  out  16: read data; valid when done is high.
REQ-006 DRP primitive ports:
- drp_en  out  1
- drp_we  out  1
- drp_addr  out  AW
- drp_di  out  16
- drp_do  in  16
- drp_rdy  in  1

Function
REQ-007 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-008 IDLE, any req high: select the first requester at or after rr_ptr (round-robin, wrapping at NREQ-1); latch its we/addr/di into drp_we/drp_addr/drp_di; set gnt[sel]; go to ISSUE.
REQ-009 ISSUE: drp_en SHALL be 1 for exactly this one cycle; clear the timeout counter; go to WAIT.
REQ-010 WAIT, drp_rdy=1:
- capture drp_do into rdata (also for writes);
- go to RESP with the done path.
REQ-011 WAIT, drp_rdy=0: increment the counter; when the counter reaches TIMEOUT-1, go to RESP with the err path and set rdata=16'h0000.
REQ-012 If drp_rdy arrives on the same cycle the counter reaches TIMEOUT-1, drp_rdy SHALL win (done, not err).
REQ-013 RESP:
- pulse done[sel] or err[sel] for one cycle;
- clear gnt;
- set rr_ptr = sel+1 (mod NREQ);
- go to IDLE.
REQ-014 Minimum transaction time: 4 cycles (IDLE->ISSUE->WAIT->RESP) when drp_rdy returns in the first WAIT cycle. Back-to-back grants SHALL have no extra idle cycle: IDLE re-arbitrates on the cycle after RESP.
REQ-015 The requester holds req and its operands until done or err. Dropping req mid-transaction SHALL NOT abort the transaction; completion still pulses.
REQ-016 drp_rdy outside WAIT SHALL be ignored.
REQ-017 drp_we/drp_addr/drp_di SHALL be held stable from ISSUE through RESP.
REQ-018 At most one gnt bit high; at most one drp_en per grant.

Reset
REQ-019 On rst, asynchronously:
- state = IDLE, rr_ptr = 0, counter = 0;
- drp_en, drp_we = 0;
- drp_addr, drp_di, rdata = 0;
- gnt, done, err = 0.
REQ-020 Reset asserted mid-transaction SHALL abandon it with no done/err pulse; after release, arbitration restarts from requester 0.

Structure
REQ-021 The shared package drp_pkg SHALL hold:
- the state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11);
- default TIMEOUT and AW;
- the rdata timeout value 16'h0000.
REQ-022 One sub-module, rr_select: combinational round-robin priority pick (req, rr_ptr -> sel, any). The FSM, latches and counter stay in drp_arbiter.

Verification
REQ-023 Single read: req[1]=1, addr 9'h05F, drp_rdy 3 cycles after drp_en with drp_do=16'hA5C3 -> one drp_en pulse with drp_we=0, addr 9'h05F; done[1] pulse; rdata=16'hA5C3.
REQ-024 Write: req[2]=1, we=1, addr 9'h011, di=16'h1234 -> drp_we=1, drp_di=16'h1234 held until RESP; done[2] pulse.
REQ-025 Fairness: req[0] and req[3] held continuously, each ack 1 cycle after drp_en -> grants alternate 0,3,0,3; each transaction takes 4 cycles with no gaps.
REQ-026 Timeout: req[0], drp_rdy never asserted, TIMEOUT=64 -> err[0] pulse, rdata=0, done silent, gnt cleared; the next request proceeds normally.
REQ-027 Edge cases:
- stray drp_rdy in IDLE -> no effect;
- drp_rdy on the last timeout cycle -> done, not err;
- rst in WAIT -> all outputs 0, no pulse; next grant goes to the lowest pending index.
